// File: rtl/exe_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: bit-serial shift-add multiply and restoring divide,
// with a fast path for divide-by-zero and signed overflow.
module exe_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_op1,
  input  logic [XLEN-1:0] in_op2,
  input  logic [63:0]     in_inst_id,
  input  logic            kill,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [63:0]     out_inst_id
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct3_q;
  logic [63:0]       inst_id_q;
  logic              sign1_q, sign2_q, divz_q, ovf_q;
  logic [XLEN-1:0]   mag1_q, mag2_q;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
  logic [5:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [63:0]       out_id_q;

  logic            accept, load, fix_en;
  logic            in_signed1, in_signed2, in_sign1, in_sign2, in_divz, in_ovf;
  logic [XLEN-1:0] in_mag1, in_mag2;

  assign in_ready    = (state_q == StIdle) || (state_q == StDone);
  assign accept      = in_valid && in_ready && !kill;
  assign out_valid   = (state_q == StDone);
  assign out_result  = result_q;
  assign out_inst_id = out_id_q;

  // MUL is treated as signed in both operands so the magnitude product can be re-signed
  assign in_signed1 = in_funct3[2] ? !in_funct3[0] : (in_funct3[1:0] != 2'b11);
  assign in_signed2 = in_funct3[2] ? !in_funct3[0] : !in_funct3[1];
  assign in_sign1   = in_signed1 && in_op1[XLEN-1];
  assign in_sign2   = in_signed2 && in_op2[XLEN-1];
  assign in_mag1    = in_sign1 ? -in_op1 : in_op1;
  assign in_mag2    = in_sign2 ? -in_op2 : in_op2;
  assign in_divz    = in_funct3[2] && (in_op2 == '0);
  assign in_ovf     = in_funct3[2] && !in_funct3[0] && (in_op2 == '1) &&
                      (in_op1 == {1'b1, {(XLEN-1){1'b0}}});

  // One datapath step: multiply shifts right through acc, divide shifts quotient in at bit 0
  logic [XLEN:0] mul_sum, div_shift, div_diff;
  logic          div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (mag2_q[cnt_q[4:0]] ? {1'b0, mag1_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], mag1_q[5'(XLEN-1) - cnt_q[4:0]]};
    div_ge    = (div_shift >= {1'b0, mag2_q});
    div_diff  = div_ge ? (div_shift - {1'b0, mag2_q}) : div_shift;
    acc_step  = funct3_q[2] ? {div_diff[XLEN-1:0], acc_q[XLEN-2:0], div_ge}
                            : {mul_sum, acc_q[XLEN-1:1]};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;

  always_comb begin
    prod = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
    quot = (sign1_q ^ sign2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = sign1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (funct3_q)
      3'b000:                 result_d = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_d = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        if (divz_q)     result_d = '1;
        else if (ovf_q) result_d = {1'b1, {(XLEN-1){1'b0}}};
        else            result_d = quot;
      end
      default: begin
        // Divide-by-zero remainder is op1, rebuilt from its magnitude and sign
        if (divz_q)     result_d = sign1_q ? -mag1_q : mag1_q;
        else if (ovf_q) result_d = '0;
        else            result_d = rem;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    fix_en  = 1'b0;
    case (state_q)
      StIdle: load = accept;
      StCalc: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(XLEN-1)) state_d = StFix;
      end
      StFix: begin
        fix_en  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        load    = accept;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      state_d = (in_divz || in_ovf) ? StFix : StCalc;
      acc_d   = '0;
      cnt_d   = '0;
    end
    if (kill) begin
      state_d = StIdle;
      fix_en  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      funct3_q  <= '0;
      inst_id_q <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      divz_q    <= 1'b0;
      ovf_q     <= 1'b0;
      mag1_q    <= '0;
      mag2_q    <= '0;
      result_q  <= '0;
      out_id_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      if (load) begin
        funct3_q  <= in_funct3;
        inst_id_q <= in_inst_id;
        sign1_q   <= in_sign1;
        sign2_q   <= in_sign2;
        divz_q    <= in_divz;
        ovf_q     <= in_ovf;
        mag1_q    <= in_mag1;
        mag2_q    <= in_mag2;
      end
      if (fix_en) begin
        result_q <= result_d;
        out_id_q <= inst_id_q;
      end
    end
  end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Scoreboard bench for exe_muldiv_unit: expected results are queued at issue and
// compared as each result comes out, along with latency, kill and reset behaviour.
module tb_exe_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, in_valid, kill;
  logic        in_ready, out_valid;
  logic [2:0]  in_funct3;
  logic [31:0] in_op1, in_op2, out_result;
  logic [63:0] in_inst_id, out_inst_id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0] next_id = 64'hC0DE_0000_0000_0001;

  typedef struct {
    logic [63:0] id;
    logic [31:0] res;
  } exp_t;
  exp_t sb_q[$];

  exe_muldiv_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct3  (in_funct3),
    .in_op1     (in_op1),
    .in_op2     (in_op2),
    .in_inst_id (in_inst_id),
    .kill       (kill),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_inst_id(out_inst_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    longint la, lb;
    logic ovf;
    la  = longint'($signed(a));
    lb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0, 3'd1: p = 64'(la * lb);
      3'd2:       p = 64'(la * longint'({32'h0, b}));
      default:    p = {32'h0, a} * {32'h0, b};
    endcase
    model = p[31:0];
    if (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3) model = p[63:32];
    if (f3 == 3'd4) begin
      if (b == 0)   model = 32'hFFFF_FFFF;
      else if (ovf) model = 32'h8000_0000;
      else          model = 32'(la / lb);
    end
    if (f3 == 3'd5) begin
      if (b == 0) model = 32'hFFFF_FFFF;
      else        model = a / b;
    end
    if (f3 == 3'd6) begin
      if (b == 0)   model = a;
      else if (ovf) model = 32'h0;
      else          model = 32'(la % lb);
    end
    if (f3 == 3'd7) begin
      if (b == 0) model = a;
      else        model = a % b;
    end
  endfunction

  // Presents one instruction and returns the cycle count at its accepting edge
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit track, input bit now, output int acc);
    logic [63:0] id;
    id = next_id;
    next_id = next_id + 64'd1;
    if (!now) @(negedge clk);
    in_valid = 1'b1; in_funct3 = f3; in_op1 = a; in_op2 = b; in_inst_id = id;
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
    in_op1 = $urandom; in_op2 = $urandom; in_funct3 = 3'($urandom);
    if (track) sb_q.push_back('{id, model(f3, a, b)});
  endtask

  task automatic wait_out(output bit got, output logic [31:0] res, output logic [63:0] id,
                          output int at, output int rdy_hi);
    got = 1'b0; res = '0; id = '0; at = 0; rdy_hi = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1; res = out_result; id = out_inst_id; at = cyc;
      end else if (in_ready) begin
        rdy_hi++;
      end
    end
  endtask

  task automatic pop_exp(output bit have, output exp_t e);
    have = sb_q.size() > 0;
    if (have) e = sb_q.pop_front();
    else e = '{64'h0, 32'h0};
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output bit ok, output logic [31:0] res, output logic [63:0] id,
                        output exp_t e, output int lat, output int rdy_hi);
    int acc, at;
    bit got, have;
    issue(f3, a, b, 1'b1, 1'b0, acc);
    wait_out(got, res, id, at, rdy_hi);
    pop_exp(have, e);
    ok  = got && have;
    lat = at - acc + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; kill = 1'b0;
    in_funct3 = '0; in_op1 = '0; in_op2 = '0; in_inst_id = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    checks++;
    if (out_result !== 32'h0 || out_inst_id !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs result=%h id=%h, required 0 0", out_result, out_inst_id);
    end
    reset = 1'b0;
  endtask

  task automatic test_mul();
    logic [2:0]  f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd3};
    logic [31:0] a  [6] = '{32'h7, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                            32'h1234_5678, 32'hFFFF_FFFF};
    logic [31:0] b  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'h9ABC_DEF0, 32'hFFFF_FFFF};
    bit ok; logic [31:0] res; logic [63:0] id; exp_t e; int lat, rdy;
    for (int i = 0; i < 6; i++) begin
      run_op(f3[i], a[i], b[i], ok, res, id, e, lat, rdy);
      checks++;
      if (!ok || res !== e.res || id !== e.id) begin
        errors++;
        $display("FAIL mul[%0d] result=%h id=%h seen=%0d, required result=%h id=%h",
                 i, res, id, ok, e.res, e.id);
      end
      if (i == 0) begin
        checks++;
        if (lat != 34 || rdy != 0) begin
          errors++;
          $display("FAIL mul_timing valid_cycle=%0d ready_high_cycles=%0d, required 34 0",
                   lat, rdy);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL mul_one_cycle out_valid=%b after DONE, required 0", out_valid);
        end
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3 [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] a  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'h7FFF_FFFF, 32'h8000_0001};
    logic [31:0] b  [6] = '{32'h2, 32'h2, 32'h10, 32'h10, 32'hFFFF_FFF3, 32'h7};
    bit ok; logic [31:0] res; logic [63:0] id; exp_t e; int lat, rdy;
    for (int i = 0; i < 6; i++) begin
      run_op(f3[i], a[i], b[i], ok, res, id, e, lat, rdy);
      checks++;
      if (!ok || res !== e.res || id !== e.id || lat != 34) begin
        errors++;
        $display("FAIL div[%0d] result=%h id=%h cycle=%0d, required result=%h id=%h cycle=34",
                 i, res, id, lat, e.res, e.id);
      end
    end
  endtask

  task automatic test_fast();
    logic [2:0]  f3 [7] = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7, 3'd6};
    logic [31:0] a  [7] = '{32'h5, 32'h5, 32'h8000_0000, 32'h8000_0000, 32'h5, 32'hABCD_0000,
                            32'hFFFF_FFF9};
    logic [31:0] b  [7] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    bit ok; logic [31:0] res; logic [63:0] id; exp_t e; int lat, rdy;
    for (int i = 0; i < 7; i++) begin
      run_op(f3[i], a[i], b[i], ok, res, id, e, lat, rdy);
      checks++;
      if (!ok || res !== e.res || id !== e.id || lat != 2) begin
        errors++;
        $display("FAIL fast[%0d] result=%h id=%h cycle=%0d, required result=%h id=%h cycle=2",
                 i, res, id, lat, e.res, e.id);
      end
    end
  endtask

  task automatic test_random();
    bit ok; logic [31:0] res, a, b; logic [63:0] id; exp_t e; int lat, rdy;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom >> ($urandom % 32);
      run_op(3'(i % 8), a, b, ok, res, id, e, lat, rdy);
      checks++;
      if (!ok || res !== e.res || id !== e.id) begin
        errors++;
        $display("FAIL random[%0d] f3=%0d a=%h b=%h result=%h, required %h",
                 i, i % 8, a, b, res, e.res);
      end
    end
  endtask

  // Aborts a DIVU in cycle 10 via kill or reset, then runs a MUL accepted in cycle 12
  task automatic test_abort(input bit use_reset);
    int acc_d, acc_m, at, rdy;
    bit got, have; logic [31:0] res; logic [63:0] id; exp_t e;
    issue(3'd5, 32'hFFFF_FFFF, 32'h3, 1'b0, 1'b0, acc_d);
    repeat (10) @(negedge clk);
    if (use_reset) reset = 1'b1;
    else kill = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort%0d_idle out_valid=%b in_ready=%b, required 0 1",
               use_reset, out_valid, in_ready);
    end
    if (use_reset) begin
      checks++;
      if (out_result !== 32'h0 || out_inst_id !== 64'h0) begin
        errors++;
        $display("FAIL reset_mid_outputs result=%h id=%h, required 0 0", out_result, out_inst_id);
      end
    end
    // An accept attempt while kill is high must be ignored
    kill = 1'b1; in_valid = 1'b1; in_funct3 = 3'd4; in_op2 = 32'h0; in_inst_id = 64'hDEAD;
    @(posedge clk);
    #1;
    kill = 1'b0; in_valid = 1'b0;
    issue(3'd0, 32'h0000_1234, 32'hFFFF_0003, 1'b1, 1'b0, acc_m);
    wait_out(got, res, id, at, rdy);
    pop_exp(have, e);
    checks++;
    if (!got || !have || res !== e.res || id !== e.id || (at - acc_d + 1) != 46) begin
      errors++;
      $display("FAIL abort%0d_next result=%h id=%h cycle=%0d, required result=%h id=%h cycle=46",
               use_reset, res, id, at - acc_d + 1, e.res, e.id);
    end
  endtask

  task automatic test_back_to_back(input bit fast);
    int acc1, acc2, at1, at2, rdy;
    bit got1, got2, h1, h2; logic [31:0] r1, r2; logic [63:0] id1, id2; exp_t e1, e2;
    int want;
    want = fast ? 36 : 68;
    issue(3'd3, 32'hDEAD_BEEF, 32'h0001_0001, 1'b1, 1'b0, acc1);
    wait_out(got1, r1, id1, at1, rdy);
    if (fast) issue(3'd7, 32'h0000_0055, 32'h0, 1'b1, 1'b1, acc2);
    else issue(3'd4, 32'h8765_4321, 32'h0000_0123, 1'b1, 1'b1, acc2);
    wait_out(got2, r2, id2, at2, rdy);
    pop_exp(h1, e1);
    pop_exp(h2, e2);
    checks++;
    if (!got1 || !h1 || r1 !== e1.res || id1 !== e1.id || (at1 - acc1 + 1) != 34) begin
      errors++;
      $display("FAIL b2b%0d_first result=%h id=%h cycle=%0d, required result=%h id=%h cycle=34",
               fast, r1, id1, at1 - acc1 + 1, e1.res, e1.id);
    end
    checks++;
    if (!got2 || !h2 || r2 !== e2.res || id2 !== e2.id || (at2 - acc1 + 1) != want) begin
      errors++;
      $display("FAIL b2b%0d_second result=%h id=%h cycle=%0d, required result=%h id=%h cycle=%0d",
               fast, r2, id2, at2 - acc1 + 1, e2.res, e2.id, want);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast();
    test_random();
    test_abort(1'b0);
    test_abort(1'b1);
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
